// File: rtl/fp16_mult.sv
// IEEE-754 binary16 multiplier: combinational multiply/round, one registered output stage.
// Optional macro FP16_MULT_SPECIALS_EN enables NaN/Inf handling and overflow-to-Inf.
module fp16_mult (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] result
);

  localparam int unsigned EXP_W  = 5;
  localparam int unsigned FRAC_W = 10;
  localparam int unsigned SIG_W  = FRAC_W + 1;
  localparam int unsigned PROD_W = 2 * SIG_W;
  localparam int unsigned E_W    = 8;

  logic [15:0]        result_d;
  logic [15:0]        result_q;

  logic               s;
  logic [EXP_W-1:0]   ea, eb;
  logic [FRAC_W-1:0]  fa, fb;
  logic [PROD_W-1:0]  p;
  logic signed [E_W-1:0] e_base, e_norm, e_fin;
  logic [FRAC_W-1:0]  frac;
  logic               guard, sticky, inc;
  logic [FRAC_W:0]    frac_rnd;
  logic               a_zero, b_zero;
`ifdef FP16_MULT_SPECIALS_EN
  logic               a_nan, b_nan, a_inf, b_inf;
`endif

  // Significand product, normalisation and round-to-nearest-even
  always_comb begin
    s        = a[15] ^ b[15];
    ea       = a[14:10];
    eb       = b[14:10];
    fa       = a[9:0];
    fb       = b[9:0];
    a_zero   = (ea == '0);
    b_zero   = (eb == '0);
    p        = PROD_W'({1'b1, fa}) * PROD_W'({1'b1, fb});
    e_base   = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 8'sd15;
    e_norm   = e_base;
    frac     = p[19:10];
    guard    = p[9];
    sticky   = |p[8:0];
    if (p[21]) begin
      frac   = p[20:11];
      guard  = p[10];
      sticky = |p[9:0];
      e_norm = e_base + 8'sd1;
    end
    inc      = guard & (sticky | frac[0]);
    frac_rnd = {1'b0, frac} + (FRAC_W + 1)'(inc);
    // A rounding carry leaves frac_rnd[9:0] already zero
    e_fin    = e_norm + $signed({7'b0000000, frac_rnd[FRAC_W]});
  end

  // Result selection: specials, zero flush, underflow, overflow, normal
  always_comb begin
    result_d = {s, e_fin[4:0], frac_rnd[FRAC_W-1:0]};
`ifdef FP16_MULT_SPECIALS_EN
    a_nan = (ea == '1) && (fa != '0);
    b_nan = (eb == '1) && (fb != '0);
    a_inf = (ea == '1) && (fa == '0);
    b_inf = (eb == '1) && (fb == '0);
    if (a_nan || b_nan) begin
      result_d = 16'h7E00;
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      result_d = 16'h7E00;
    end else if (a_inf || b_inf) begin
      result_d = {s, 5'h1F, 10'h000};
    end else if (a_zero || b_zero) begin
      result_d = {s, 15'h0000};
    end else if (e_fin <= 8'sd0) begin
      result_d = {s, 15'h0000};
    end else if (e_fin >= 8'sd31) begin
      result_d = {s, 15'h7C00};
    end
`else
    if (a_zero || b_zero) begin
      result_d = {s, 15'h0000};
    end else if (e_fin <= 8'sd0) begin
      result_d = {s, 15'h0000};
    end else if (e_fin >= 8'sd31) begin
      result_d = {s, 15'h7BFF};
    end
`endif
    if (rst) begin
      result_d = 16'h0000;
    end
  end

  always_ff @(posedge clk) begin
    result_q <= result_d;
  end

  assign result = result_q;

endmodule

// File: tb/tb_fp16_mult.sv
// Directed scoreboard bench for fp16_mult; expectations are hand-derived binary16 products.
module tb_fp16_mult;

  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] result;

  int unsigned n_checks;
  int unsigned n_fails;

  logic [15:0] exp_q[$];
  string       tag_q[$];

  fp16_mult dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operand pair, push its expectation, check it one edge later
  task automatic step(input logic r, input logic [15:0] av, input logic [15:0] bv,
                      input logic [15:0] ev, input string tag);
    logic [15:0] ex;
    string       tg;
    rst = r;
    a   = av;
    b   = bv;
    exp_q.push_back(ev);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    ex = exp_q.pop_front();
    tg = tag_q.pop_front();
    n_checks++;
    assert (result === ex) else begin
      n_fails++;
      $error("FAIL %s: result=%h expected=%h", tg, result, ex);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst = 1'b1;
    a   = 16'h0000;
    b   = 16'h0000;
    #2;

    step(1'b1, 16'h3C00, 16'h3C00, 16'h0000, "reset_0");
    step(1'b1, 16'h3C00, 16'h3C00, 16'h0000, "reset_1");
    step(1'b0, 16'h3C00, 16'h3C00, 16'h3C00, "first_after_reset");

    step(1'b0, 16'hBC33, 16'h3C00, 16'hBC33, "norm_bc33");
    step(1'b0, 16'h5620, 16'h5600, 16'h7098, "norm_7098");
    step(1'b0, 16'hD160, 16'h54C0, 16'hEA62, "norm_ea62");
    step(1'b0, 16'hE218, 16'h4600, 16'hEC92, "norm_ec92");

    step(1'b0, 16'h3C00, 16'h3C01, 16'h3C01, "rnd_one_ulp");
    step(1'b0, 16'h3C01, 16'h3C01, 16'h3C02, "rnd_sticky_only");
    step(1'b0, 16'h3E00, 16'h3C01, 16'h3E02, "rnd_tie_odd_up");
    step(1'b0, 16'h3C03, 16'h3E00, 16'h3E04, "rnd_tie_even_hold");
    step(1'b0, 16'h3DA8, 16'h3DA8, 16'h4000, "rnd_carry_out");

    step(1'b0, 16'h0000, 16'h0000, 16'h0000, "zero_zero");
    step(1'b0, 16'h3C00, 16'h0000, 16'h0000, "one_zero");
    step(1'b0, 16'hBC00, 16'h0000, 16'h8000, "neg_zero");
    step(1'b0, 16'h0400, 16'h0400, 16'h0000, "underflow");
    step(1'b0, 16'h03FF, 16'h3C00, 16'h0000, "subnormal_flush");

`ifdef FP16_MULT_SPECIALS_EN
    step(1'b0, 16'h7BFF, 16'h4000, 16'h7C00, "overflow_inf");
    step(1'b0, 16'h7E00, 16'h3C00, 16'h7E00, "nan_in");
    step(1'b0, 16'h7C00, 16'h0000, 16'h7E00, "inf_times_zero");
    step(1'b0, 16'hFC00, 16'h3C00, 16'hFC00, "neg_inf");
`else
    step(1'b0, 16'h7BFF, 16'h4000, 16'h7BFF, "overflow_sat");
    step(1'b0, 16'hFBFF, 16'h4000, 16'hFBFF, "overflow_sat_neg");
    step(1'b0, 16'h7C00, 16'h3C00, 16'h7BFF, "exp31_ordinary");
`endif

    // Reset in the middle of a stream, then resume
    step(1'b1, 16'h5620, 16'h5600, 16'h0000, "reset_mid");
    step(1'b0, 16'h5620, 16'h5600, 16'h7098, "resume_after_reset");
    step(1'b0, 16'hBC33, 16'h3C00, 16'hBC33, "resume_b2b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
